zbus_target: RTL and testbench
==============================

# zbus_target

Synchronous Z80 bus responder for the CPLD. It samples the asynchronous Z80 strobes (/MREQ, /IORQ, /RD, /WR), address and data into the `clk` domain and decodes I/O accesses to one port. It turns each accepted access into a single-cycle register-file read or write request. It drives read data back onto the Z80 data bus through a separate output-enable. It sits between the Z80 pin interface and the internal register bank.

## Interface
- `PORT_LO`, 8'hAB: value `a[7:0]` must match for an I/O access to be decoded.
- `REG_BITS`, 4: register index width, taken from `a[8 +: REG_BITS]`.
- `MEM_PAGE`, 8'h3F: `a[15:8]` match for the memory window; present only with `ZBUS_MEM_EN`.
- `clk` in 1: single system clock; all logic is on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `mreq_n` in 1: Z80 /MREQ, asynchronous.
- `iorq_n` in 1: Z80 /IORQ, asynchronous.
- `rd_n` in 1: Z80 /RD, asynchronous.
- `wr_n` in 1: Z80 /WR, asynchronous.
- `a` in 16: Z80 address, asynchronous.
- `d_in` in 8: Z80 data bus as seen at the pad.
- `d_out` out 8: read data toward the pad.
- `d_oe` out 1: pad output enable for `d_out`.
- `reg_idx` out REG_BITS: register index for the current access.
- `reg_wdata` out 8: write data.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rd` out 1: one-cycle read strobe.
- `reg_rdata` in 8: register read data, valid in the cycle after `reg_rd`.
- `busy` out 1: high while the FSM is not in IDLE.

## Operation
- Each of `mreq_n`, `iorq_n`, `rd_n`, `wr_n` passes through a 2-flop synchronizer; the second stage is the "seen" value. `a` and `d_in` are sampled unsynchronized, and only when the FSM captures them.
- Access condition `io_rd`: seen `iorq_n`=0, `rd_n`=0, `wr_n`=1, `a[7:0]`==PORT_LO. `io_wr` is the same with `wr_n`=0 and `rd_n`=1.
- FSM states: ARM, IDLE, RD_REQ, RD_DRV, WR, WAIT_REL.
  - ARM (reset state): wait until seen `rd_n`=1 and `wr_n`=1, then go to IDLE. A strobe already active at reset release is never serviced.
  - IDLE, on `io_rd`: latch `reg_idx`, pulse `reg_rd`, go to RD_REQ.
  - IDLE, on `io_wr`: latch `reg_idx` and `reg_wdata`=`d_in`, go to WR.
  - IDLE, both strobes seen low, or a strobe with no address match: go to WAIT_REL with no register access.
  - RD_REQ: `d_out`<=`reg_rdata`, `d_oe`<=1, go to RD_DRV.
  - RD_DRV: hold `d_out` and `d_oe`. When seen `rd_n`=1 or seen `iorq_n`=1: `d_oe`<=0, go to IDLE.
  - WR: pulse `reg_wr` for one cycle, go to WAIT_REL.
  - WAIT_REL: wait for seen `rd_n`=1 and `wr_n`=1, then go to IDLE.
- Exactly one `reg_rd` or `reg_wr` per Z80 access, regardless of strobe length.
- The address is latched once per access; later changes to `a` are ignored until IDLE.
- Reset values: `d_out`=0, `d_oe`=0, `reg_idx`=0, `reg_wdata`=0, `reg_wr`=0, `reg_rd`=0, `busy`=1 (state ARM).
- Reset mid-access: `d_oe` drops in the next cycle, any pending `reg_wr` is lost, and the FSM re-enters ARM.

## Timing
- Strobe edge to seen value: 2 `clk`.
- Read: `reg_rd` 3 cycles after the /RD fall, `d_oe` 5 cycles after, and `d_oe` low 3 cycles after the /RD rise.
- Write: `d_in` captured 3 cycles after the /WR fall, `reg_wr` 4 cycles after.
- `clk` must be at least 4× the Z80 clock so read data is valid before the Z80 samples it. The Z80 holds /RD low for about 2 Z80 clocks.
- `d_in` must be stable from the /WR fall to its rise. The Z80 guarantees this.
- Back-to-back accesses need only one IDLE cycle between them.

## Configuration
- `ZBUS_MEM_EN` defined: memory accesses are also decoded. The conditions are seen `mreq_n`=0 with `a[15:8]`==MEM_PAGE, the matching strobe, and register index `a[REG_BITS-1:0]`. They use the same states and timing as I/O accesses.
- `ZBUS_MEM_EN` undefined: `mreq_n` is ignored entirely and the `MEM_PAGE` logic is absent.

## Test plan
- I/O write 0x5A to port 16'h03AB → `reg_wr` high exactly one cycle with `reg_idx`=3, `reg_wdata`=8'h5A.
- I/O read port 16'h07AB with `reg_rdata`=8'hC3 → one `reg_rd` with `reg_idx`=7; `d_out`=8'hC3 and `d_oe`=1 while /RD is low; `d_oe`=0 within 3 cycles of the /RD rise.
- I/O write to port 16'h03AC → no `reg_wr`, no `reg_rd`, `d_oe` stays 0.
- Hold /RD low and assert `rst` during RD_DRV → `d_oe`=0 the next cycle; after `rst` is released no `reg_rd` occurs until /RD rises and falls again.
- Two I/O writes separated by 2 Z80 clocks (0x11 to reg 1, then 0x22 to reg 2) → two `reg_wr` pulses in order with the matching data.
- With `ZBUS_MEM_EN`: memory write 0x99 to 16'h3F05 → `reg_wr` with `reg_idx`=5. Without it, the same cycle → no strobe.

Source files
------------

// File: rtl/zbus_target.sv
`default_nettype none
// ============================================================================
// Module   : zbus_target
// Purpose  : Z80 bus responder. Synchronises the Z80 strobes, decodes one I/O
//            port (plus a memory page when ZBUS_MEM_EN is defined) and issues
//            single-cycle register-file read/write strobes.
// Revision : 1.0  initial release
// ============================================================================
module zbus_target #(
   parameter logic [7:0] PORT_LO  = 8'hAB,
   parameter int         REG_BITS = 4
`ifdef ZBUS_MEM_EN
   ,
   parameter logic [7:0] MEM_PAGE = 8'h3F
`endif
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mreq_n,
   input  logic                iorq_n,
   input  logic                rd_n,
   input  logic                wr_n,
   input  logic [15:0]         a,
   input  logic [7:0]          d_in,
   output logic [7:0]          d_out,
   output logic                d_oe,
   output logic [REG_BITS-1:0] reg_idx,
   output logic [7:0]          reg_wdata,
   output logic                reg_wr,
   output logic                reg_rd,
   input  logic [7:0]          reg_rdata,
   output logic                busy
);

   typedef enum logic [2:0] {
      ST_ARM      = 3'd0,
      ST_IDLE     = 3'd1,
      ST_RD_REQ   = 3'd2,
      ST_RD_DRV   = 3'd3,
      ST_WR       = 3'd4,
      ST_WAIT_REL = 3'd5
   } state_t;

   // Strobe vector order: [0]=wr_n [1]=rd_n [2]=iorq_n [3]=mreq_n.
   // rd/wr reset to "active" so ARM only leaves once a genuine release is seen.
`ifdef ZBUS_MEM_EN
   localparam int c_NSYNC = 4;
   logic [c_NSYNC-1:0] w_strb_raw;
   assign w_strb_raw = {mreq_n, iorq_n, rd_n, wr_n};
`else
   localparam int c_NSYNC = 3;
   logic [c_NSYNC-1:0] w_strb_raw;
   logic               w_unused_bits;
   assign w_strb_raw    = {iorq_n, rd_n, wr_n};
   assign w_unused_bits = ^{mreq_n, a};
`endif
   localparam logic [c_NSYNC-1:0] c_SYNC_RST = {{(c_NSYNC-2){1'b1}}, 2'b00};

   logic [c_NSYNC-1:0]  r_sync1;
   logic [c_NSYNC-1:0]  r_sync2;

   state_t              r_state;
   state_t              w_state_nx;
   logic [7:0]          r_d_out;
   logic [7:0]          w_d_out_nx;
   logic                r_d_oe;
   logic                w_d_oe_nx;
   logic [REG_BITS-1:0] r_reg_idx;
   logic [REG_BITS-1:0] w_reg_idx_nx;
   logic [7:0]          r_reg_wdata;
   logic [7:0]          w_reg_wdata_nx;
   logic                r_reg_wr;
   logic                w_reg_wr_nx;
   logic                r_reg_rd;
   logic                w_reg_rd_nx;

   logic                w_wr_s;
   logic                w_rd_s;
   logic                w_iorq_s;
   logic                w_rd_act;
   logic                w_wr_act;
   logic                w_any_strb;
   logic                w_io_hit;
   logic                w_hit;
   logic                w_cyc;
   logic                w_rd_rel;
   logic [REG_BITS-1:0] w_idx;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= c_SYNC_RST;
         r_sync2 <= c_SYNC_RST;
      end else begin
         r_sync1 <= w_strb_raw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_wr_s     = r_sync2[0];
   assign w_rd_s     = r_sync2[1];
   assign w_iorq_s   = r_sync2[2];
   assign w_rd_act   = ~w_rd_s &  w_wr_s;
   assign w_wr_act   =  w_rd_s & ~w_wr_s;
   assign w_any_strb = ~w_rd_s | ~w_wr_s;
   assign w_io_hit   = ~w_iorq_s & (a[7:0] == PORT_LO);

`ifdef ZBUS_MEM_EN
   logic w_mreq_s;
   logic w_mem_hit;
   logic r_mem_acc;
   logic w_mem_acc_nx;

   assign w_mreq_s  = r_sync2[3];
   assign w_mem_hit = ~w_mreq_s & w_iorq_s & (a[15:8] == MEM_PAGE);
   assign w_hit     = w_io_hit | w_mem_hit;
   assign w_cyc     = ~w_iorq_s | ~w_mreq_s;
   assign w_idx     = w_io_hit ? a[8 +: REG_BITS] : a[REG_BITS-1:0];
   // A memory read is released by /MREQ instead of /IORQ.
   assign w_rd_rel  = w_rd_s | (r_mem_acc ? w_mreq_s : w_iorq_s);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_acc <= 1'b0;
      end else begin
         r_mem_acc <= w_mem_acc_nx;
      end
   end
`else
   assign w_hit    = w_io_hit;
   assign w_cyc    = ~w_iorq_s;
   assign w_idx    = a[8 +: REG_BITS];
   assign w_rd_rel = w_rd_s | w_iorq_s;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_ARM;
         r_d_out     <= 8'h00;
         r_d_oe      <= 1'b0;
         r_reg_idx   <= '0;
         r_reg_wdata <= 8'h00;
         r_reg_wr    <= 1'b0;
         r_reg_rd    <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_d_out     <= w_d_out_nx;
         r_d_oe      <= w_d_oe_nx;
         r_reg_idx   <= w_reg_idx_nx;
         r_reg_wdata <= w_reg_wdata_nx;
         r_reg_wr    <= w_reg_wr_nx;
         r_reg_rd    <= w_reg_rd_nx;
      end
   end

   always_comb begin
      w_state_nx     = r_state;
      w_d_out_nx     = r_d_out;
      w_d_oe_nx      = r_d_oe;
      w_reg_idx_nx   = r_reg_idx;
      w_reg_wdata_nx = r_reg_wdata;
      w_reg_wr_nx    = 1'b0;
      w_reg_rd_nx    = 1'b0;
`ifdef ZBUS_MEM_EN
      w_mem_acc_nx   = r_mem_acc;
`endif
      case (r_state)
         ST_ARM: begin
            if (w_rd_s && w_wr_s) begin
               w_state_nx = ST_IDLE;
            end
         end
         ST_IDLE: begin
            // A lone /RD or /WR without /IORQ (or /MREQ) is not a cycle yet.
            if (w_cyc && w_any_strb) begin
               if (w_hit && w_rd_act) begin
                  w_reg_idx_nx = w_idx;
                  w_reg_rd_nx  = 1'b1;
                  w_state_nx   = ST_RD_REQ;
`ifdef ZBUS_MEM_EN
                  w_mem_acc_nx = w_mem_hit;
`endif
               end else if (w_hit && w_wr_act) begin
                  w_reg_idx_nx   = w_idx;
                  w_reg_wdata_nx = d_in;
                  w_state_nx     = ST_WR;
               end else begin
                  w_state_nx = ST_WAIT_REL;
               end
            end
         end
         ST_RD_REQ: begin
            // Register data arrives the cycle after the read strobe.
            if (!r_reg_rd) begin
               w_d_out_nx = reg_rdata;
               w_d_oe_nx  = 1'b1;
               w_state_nx = ST_RD_DRV;
            end
         end
         ST_RD_DRV: begin
            if (w_rd_rel) begin
               w_d_oe_nx  = 1'b0;
               w_state_nx = ST_IDLE;
            end
         end
         ST_WR: begin
            w_reg_wr_nx = 1'b1;
            w_state_nx  = ST_WAIT_REL;
         end
         ST_WAIT_REL: begin
            if (w_rd_s && w_wr_s) begin
               w_state_nx = ST_IDLE;
            end
         end
         default: begin
            w_state_nx = ST_ARM;
         end
      endcase
   end

   assign d_out     = r_d_out;
   assign d_oe      = r_d_oe;
   assign reg_idx   = r_reg_idx;
   assign reg_wdata = r_reg_wdata;
   assign reg_wr    = r_reg_wr;
   assign reg_rd    = r_reg_rd;
   assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_zbus_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_zbus_target
// Purpose  : Scoreboard bench for zbus_target: Z80 bus stimulus, register-bank
//            model and a monitor checking strobes, data and latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_zbus_target;

`ifdef ZBUS_MEM_EN
   localparam bit MEM_EN = 1'b1;
`else
   localparam bit MEM_EN = 1'b0;
`endif

   typedef struct {
      logic [3:0] idx;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mreq_n = 1'b1;
   logic        iorq_n = 1'b1;
   logic        rd_n = 1'b1;
   logic        wr_n = 1'b1;
   logic [15:0] a = 16'h0000;
   logic [7:0]  d_in = 8'h00;
   logic [7:0]  d_out;
   logic        d_oe;
   logic [3:0]  reg_idx;
   logic [7:0]  reg_wdata;
   logic        reg_wr;
   logic        reg_rd;
   logic [7:0]  reg_rdata = 8'h00;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   logic        prev_oe = 1'b0;
   logic        bank_load = 1'b1;
   logic [7:0]  init_val [16];
   logic [7:0]  bank     [16];
   logic [7:0]  ref_regs [16];
   exp_t        wr_q[$];
   exp_t        rd_q[$];
   exp_t        doe_q[$];

   zbus_target dut (
      .clk       (clk),
      .rst       (rst),
      .mreq_n    (mreq_n),
      .iorq_n    (iorq_n),
      .rd_n      (rd_n),
      .wr_n      (wr_n),
      .a         (a),
      .d_in      (d_in),
      .d_out     (d_out),
      .d_oe      (d_oe),
      .reg_idx   (reg_idx),
      .reg_wdata (reg_wdata),
      .reg_wr    (reg_wr),
      .reg_rd    (reg_rd),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register bank: read data is registered, so it is valid the cycle after reg_rd.
   always @(posedge clk) begin
      if (bank_load) begin
         for (int i = 0; i < 16; i++) bank[i] <= init_val[i];
      end else begin
         if (reg_rd === 1'b1) reg_rdata <= bank[reg_idx];
         if (reg_wr === 1'b1) bank[reg_idx] <= reg_wdata;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (reg_wr === 1'b1) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL reg_wr_unexpected: got idx=%0h data=%0h at cyc %0d, required no strobe", reg_idx, reg_wdata, cyc);
         end else begin
            e = wr_q.pop_front();
            if (reg_idx !== e.idx || reg_wdata !== e.data || cyc != e.cyc) begin
               bad++;
               $display("FAIL reg_wr: got idx=%0h data=%0h cyc=%0d required idx=%0h data=%0h cyc=%0d",
                        reg_idx, reg_wdata, cyc, e.idx, e.data, e.cyc);
            end
         end
      end
      if (reg_rd === 1'b1) begin
         total++;
         if (rd_q.size() == 0) begin
            bad++;
            $display("FAIL reg_rd_unexpected: got idx=%0h at cyc %0d, required no strobe", reg_idx, cyc);
         end else begin
            e = rd_q.pop_front();
            if (reg_idx !== e.idx || cyc != e.cyc) begin
               bad++;
               $display("FAIL reg_rd: got idx=%0h cyc=%0d required idx=%0h cyc=%0d", reg_idx, cyc, e.idx, e.cyc);
            end
         end
      end
      if (d_oe === 1'b1 && prev_oe !== 1'b1) begin
         total++;
         if (doe_q.size() == 0) begin
            bad++;
            $display("FAIL d_oe_unexpected: got d_oe=1 d_out=%0h at cyc %0d, required d_oe=0", d_out, cyc);
         end else begin
            e = doe_q.pop_front();
            if (d_out !== e.data || cyc != e.cyc + 2) begin
               bad++;
               $display("FAIL d_out: got data=%0h cyc=%0d required data=%0h cyc=%0d", d_out, cyc, e.data, e.cyc + 2);
            end
         end
      end
      prev_oe = d_oe;
   end

   // One complete Z80 access; expectations come from the decode rules alone.
   task automatic z80_access(input bit is_io, input bit is_wr, input logic [15:0] addr,
                             input logic [7:0] data, input int len, input int gap);
      bit         hit;
      logic [3:0] idx;
      exp_t       e;
      hit = 1'b0;
      idx = 4'h0;
      if (is_io && addr[7:0] == 8'hAB) begin
         hit = 1'b1;
         idx = addr[11:8];
      end else if (!is_io && MEM_EN && addr[15:8] == 8'h3F) begin
         hit = 1'b1;
         idx = addr[3:0];
      end
      @(negedge clk);
      a    = addr;
      d_in = data;
      if (is_io) iorq_n = 1'b0; else mreq_n = 1'b0;
      if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
      if (hit) begin
         e.idx  = idx;
         e.data = is_wr ? data : ref_regs[idx];
         e.cyc  = cyc + (is_wr ? 4 : 3);
         if (is_wr) begin
            wr_q.push_back(e);
            ref_regs[idx] = data;
         end else begin
            rd_q.push_back(e);
            doe_q.push_back(e);
         end
      end
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         if (i == 3) a = 16'($urandom);
      end
      if (!is_wr) check("d_oe_while_rd_low", d_oe, hit);
      rd_n = 1'b1; wr_n = 1'b1; iorq_n = 1'b1; mreq_n = 1'b1;
      if (!is_wr) begin
         repeat (2) @(negedge clk);
         check("d_oe_hold_after_rise", d_oe, hit);
         @(negedge clk);
         check("d_oe_release", d_oe, 1'b0);
      end
      repeat (gap) @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int   n;
      exp_t e;
      for (int i = 0; i < 16; i++) init_val[i] = 8'($urandom);
      init_val[7] = 8'hC3;
      for (int i = 0; i < 16; i++) ref_regs[i] = init_val[i];

      repeat (3) @(negedge clk);
      bank_load = 1'b0;
      check("rst_d_out", d_out, 8'h00);
      check("rst_d_oe", d_oe, 1'b0);
      check("rst_reg_idx", reg_idx, 4'h0);
      check("rst_reg_wdata", reg_wdata, 8'h00);
      check("rst_reg_wr", reg_wr, 1'b0);
      check("rst_reg_rd", reg_rd, 1'b0);
      check("rst_busy", busy, 1'b1);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_after_arm", busy, 1'b0);

      z80_access(1'b1, 1'b1, 16'h03AB, 8'h5A, 6, 3);
      z80_access(1'b1, 1'b0, 16'h07AB, 8'h00, 8, 3);
      z80_access(1'b1, 1'b1, 16'h03AC, 8'h77, 6, 3);
      check("no_oe_after_miss", d_oe, 1'b0);

      // Reset while the read data is being driven.
      @(negedge clk);
      a = 16'h07AB; iorq_n = 1'b0; rd_n = 1'b0;
      e.idx = 4'h7; e.data = ref_regs[7]; e.cyc = cyc + 3;
      rd_q.push_back(e);
      doe_q.push_back(e);
      n = 0;
      while (d_oe !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rst_test_d_oe_up", d_oe, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_d_oe", d_oe, 1'b0);
      check("rst_mid_busy", busy, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      check("arm_holds_with_rd_low", busy, 1'b1);
      check("arm_no_d_oe", d_oe, 1'b0);
      rd_n = 1'b1; iorq_n = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_after_release", busy, 1'b0);
      z80_access(1'b1, 1'b0, 16'h07AB, 8'h00, 7, 2);

      z80_access(1'b1, 1'b1, 16'h01AB, 8'h11, 6, 8);
      z80_access(1'b1, 1'b1, 16'h02AB, 8'h22, 6, 3);
      z80_access(1'b0, 1'b1, 16'h3F05, 8'h99, 6, 3);

      for (int k = 0; k < 80; k++) begin
         int          kind;
         bit          is_wr;
         logic [15:0] addr;
         logic [7:0]  lo;
         kind  = int'($urandom_range(0, 3));
         is_wr = 1'($urandom);
         addr  = {4'($urandom), 4'($urandom), 8'hAB};
         if (kind == 2) begin
            lo = 8'($urandom);
            if (lo == 8'hAB) lo = 8'hAA;
            addr[7:0] = lo;
         end else if (kind == 3) begin
            addr = {8'h3F, 4'($urandom), 4'($urandom)};
         end
         z80_access(kind != 3, is_wr, addr, 8'($urandom),
                    is_wr ? int'($urandom_range(4, 8)) : int'($urandom_range(6, 10)),
                    int'($urandom_range(2, 6)));
      end

      repeat (10) @(negedge clk);
      check("wr_queue_drained", wr_q.size(), 0);
      check("rd_queue_drained", rd_q.size(), 0);
      check("doe_queue_drained", doe_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
